// File: rtl/ght_pkg.sv
// Shared types and helpers for the banked saturating-counter history table.
package ght_pkg;

    // Widest index the update struct can carry; the table's IDX_W must be smaller.
    localparam int GHT_IDX_MAX = 16;

    // A deferred counter update: which entry, and which way the branch resolved.
    typedef struct packed {
        logic [GHT_IDX_MAX-1:0] idx;
        logic                   taken;
    } ght_upd_t;

    // Init sweep state: sweeping rows, then normal operation.
    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } ght_state_e;

    // Weakly-not-taken: MSB clear, every lower bit set.
    function automatic int weak_of(input int cw);
        return (1 << (cw - 1)) - 1;
    endfunction

    // Strongly-taken saturation value.
    function automatic int max_of(input int cw);
        return (1 << cw) - 1;
    endfunction

    // Bank number is the low BANK_BITS of the index.
    function automatic logic [GHT_IDX_MAX-1:0] bank_of(input logic [GHT_IDX_MAX-1:0] idx,
                                                        input int                     bank_bits);
        logic [GHT_IDX_MAX-1:0] mask;
        mask = GHT_IDX_MAX'((1 << bank_bits) - 1);
        return idx & mask;
    endfunction

endpackage

// File: rtl/ght_sc_bank.sv
// One bank of counters: lookup read, RMW read, a single update write and an init write.
module ght_sc_bank #(
    parameter int ROW_W = 8,
    parameter int CW    = 2
) (
    input  logic             clk,
    input  logic [ROW_W-1:0] lk_row,
    output logic [CW-1:0]    lk_ctr,
    input  logic [ROW_W-1:0] rmw_row,
    output logic [CW-1:0]    rmw_ctr,
    input  logic             we,
    input  logic [ROW_W-1:0] wr_row,
    input  logic [CW-1:0]    wr_ctr,
    input  logic             init_we,
    input  logic [ROW_W-1:0] init_row,
    input  logic [CW-1:0]    init_ctr
);

    localparam int ROWS = 1 << ROW_W;

    logic [CW-1:0] ctr_mem [ROWS];

    // Both reads are combinational so a write at this edge is seen next cycle.
    assign lk_ctr  = ctr_mem[lk_row];
    assign rmw_ctr = ctr_mem[rmw_row];

    // Init sweep and updates never overlap; init is listed first for clarity.
    always_ff @(posedge clk) begin
        if (init_we) begin
            ctr_mem[init_row] <= init_ctr;
        end else if (we) begin
            ctr_mem[wr_row] <= wr_ctr;
        end
    end

endmodule

// File: rtl/ght_sc_table.sv
// Banked saturating-counter table: registered lookup, two retire update ports,
// replay queue for same-bank conflicts, and a post-reset init sweep.
module ght_sc_table
    import ght_pkg::*;
#(
    parameter int IDX_W     = 11,
    parameter int BANK_BITS = 3,
    parameter int CW        = 2,
    parameter int QD        = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rd_en,
    input  logic                 fstall,
    input  logic [IDX_W-1:0]     rd_idx,
    output logic                 rd_valid,
    output logic                 rd_taken,
    output logic [CW-1:0]        rd_ctr,
    input  logic                 wr0_en,
    input  logic [IDX_W-1:0]     wr0_idx,
    input  logic                 wr0_taken,
    input  logic                 wr1_en,
    input  logic [IDX_W-1:0]     wr1_idx,
    input  logic                 wr1_taken,
    output logic                 init_busy,
    output logic [$clog2(QD):0]  q_count,
    output logic                 wr_drop
);

    localparam int NB    = 1 << BANK_BITS;
    localparam int ROW_W = IDX_W - BANK_BITS;
    localparam int QP_W  = $clog2(QD);
    localparam int QC_W  = QP_W + 1;
    localparam logic [CW-1:0] WEAK = CW'(weak_of(CW));
    localparam logic [CW-1:0] MAXC = CW'(max_of(CW));

    function automatic logic [BANK_BITS-1:0] bank_sel(input logic [IDX_W-1:0] idx);
        logic [GHT_IDX_MAX-1:0] full;
        full = bank_of(GHT_IDX_MAX'(idx), BANK_BITS);
        return full[BANK_BITS-1:0];
    endfunction

    function automatic logic [ROW_W-1:0] row_sel(input logic [IDX_W-1:0] idx);
        return idx[IDX_W-1:BANK_BITS];
    endfunction

    function automatic logic [CW-1:0] sat_step(input logic [CW-1:0] c, input logic t);
        if (t) return (c == MAXC) ? MAXC : c + CW'(1);
        else   return (c == '0)   ? '0   : c - CW'(1);
    endfunction

    // ---------------- state ----------------
    ght_state_e          state_q;
    logic [ROW_W-1:0]    init_cnt_q;
    logic                init_busy_q;

    logic [IDX_W-1:0]    rd_idx_q, rd_idx_d;
    logic                rd_valid_q, rd_valid_d;
    logic                wr_drop_q;

    ght_upd_t            q_mem_q [QD];
    ght_upd_t            q_mem_d [QD];
    logic [QP_W-1:0]     q_rd_q, q_rd_d, q_wr_q, q_wr_d;
    logic [QC_W-1:0]     q_cnt_q, q_cnt_d;

    // ---------------- arbitration ----------------
    ght_upd_t            head, u0, u1;
    logic [BANK_BITS-1:0] hb, b0, b1, rb;
    logic                hv, w0_en, w1_en, p0_lose, p1_lose, push0, push1, drop;
    int                  q_free;

    logic [NB-1:0][CW-1:0] lk_ctr;

    // Upper struct bits are always zero for this IDX_W.
    logic unused_hi;
    assign unused_hi = ^head.idx[GHT_IDX_MAX-1:IDX_W];

    // Queue head beats port 0 beats port 1; losers queue in port order while space lasts.
    always_comb begin
        head    = q_mem_q[q_rd_q];
        u0      = '{idx: GHT_IDX_MAX'(wr0_idx), taken: wr0_taken};
        u1      = '{idx: GHT_IDX_MAX'(wr1_idx), taken: wr1_taken};
        hb      = bank_sel(head.idx[IDX_W-1:0]);
        b0      = bank_sel(wr0_idx);
        b1      = bank_sel(wr1_idx);
        hv      = ~init_busy_q & (q_cnt_q != '0);
        w0_en   = ~init_busy_q & wr0_en;
        w1_en   = ~init_busy_q & wr1_en;
        p0_lose = w0_en & hv & (b0 == hb);
        p1_lose = w1_en & ((hv & (b1 == hb)) | (w0_en & (b1 == b0)));
        // Slots available after this cycle's pop.
        q_free  = QD - int'(q_cnt_q) + int'(hv);
        push0   = p0_lose & (q_free >= 1);
        push1   = p1_lose & (q_free >= (p0_lose ? 2 : 1));
        drop    = (p0_lose & ~push0) | (p1_lose & ~push1);
    end

    // Circular buffer: pop the head on dispatch, append up to two losers.
    always_comb begin
        q_mem_d = q_mem_q;
        q_rd_d  = q_rd_q + QP_W'(hv);
        q_wr_d  = q_wr_q;
        if (push0) begin
            q_mem_d[q_wr_d] = u0;
            q_wr_d          = q_wr_d + QP_W'(1);
        end
        if (push1) begin
            q_mem_d[q_wr_d] = u1;
            q_wr_d          = q_wr_d + QP_W'(1);
        end
        q_cnt_d = q_cnt_q - QC_W'(hv) + QC_W'(push0) + QC_W'(push1);
    end

    // Queue pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_rd_q  <= '0;
            q_wr_q  <= '0;
            q_cnt_q <= '0;
        end else begin
            q_rd_q  <= q_rd_d;
            q_wr_q  <= q_wr_d;
            q_cnt_q <= q_cnt_d;
        end
    end

    // Queue storage needs no reset; occupancy gates every use.
    always_ff @(posedge clk) begin
        q_mem_q <= q_mem_d;
    end

    // Init sweep: one row of every bank per cycle, then hand over to normal operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_INIT;
            init_cnt_q  <= '0;
            init_busy_q <= 1'b1;
        end else begin
            case (state_q)
                ST_INIT: begin
                    init_cnt_q <= init_cnt_q + ROW_W'(1);
                    if (init_cnt_q == '1) begin
                        state_q     <= ST_RUN;
                        init_busy_q <= 1'b0;
                    end
                end
                ST_RUN: begin
                    init_busy_q <= 1'b0;
                end
                default: begin
                    state_q     <= ST_INIT;
                    init_busy_q <= 1'b1;
                end
            endcase
        end
    end

    // Lookup address loads even under fstall; valid holds while stalled.
    always_comb begin
        rd_idx_d   = rd_en ? rd_idx : rd_idx_q;
        rd_valid_d = fstall ? rd_valid_q : (rd_en & ~init_busy_q);
    end

    // Read-side and drop-flag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_idx_q   <= '0;
            rd_valid_q <= 1'b0;
            wr_drop_q  <= 1'b0;
        end else begin
            rd_idx_q   <= rd_idx_d;
            rd_valid_q <= rd_valid_d;
            wr_drop_q  <= drop;
        end
    end

    // ---------------- banks ----------------
    for (genvar b = 0; b < NB; b++) begin : g_bank
        logic             sel_h, sel_0, sel_1, we, tk;
        logic [ROW_W-1:0] wrow;
        logic [CW-1:0]    rmw_ctr, wdat;

        // Pick this bank's single writer; arbitration guarantees at most one.
        always_comb begin
            sel_h = hv & (hb == BANK_BITS'(b));
            sel_0 = w0_en & ~p0_lose & (b0 == BANK_BITS'(b));
            sel_1 = w1_en & ~p1_lose & (b1 == BANK_BITS'(b));
            we    = sel_h | sel_0 | sel_1;
            wrow  = row_sel(wr1_idx);
            tk    = wr1_taken;
            if (sel_h) begin
                wrow = row_sel(head.idx[IDX_W-1:0]);
                tk   = head.taken;
            end else if (sel_0) begin
                wrow = row_sel(wr0_idx);
                tk   = wr0_taken;
            end
        end

        // Counter is re-read at dispatch, so queued updates never apply a stale value.
        assign wdat = sat_step(rmw_ctr, tk);

        ght_sc_bank #(
            .ROW_W (ROW_W),
            .CW    (CW)
        ) u_bank (
            .clk      (clk),
            .lk_row   (row_sel(rd_idx_q)),
            .lk_ctr   (lk_ctr[b]),
            .rmw_row  (wrow),
            .rmw_ctr  (rmw_ctr),
            .we       (we),
            .wr_row   (wrow),
            .wr_ctr   (wdat),
            .init_we  (init_busy_q),
            .init_row (init_cnt_q),
            .init_ctr (WEAK)
        );
    end

    // ---------------- outputs ----------------
    assign rb        = bank_sel(rd_idx_q);
    assign rd_ctr    = init_busy_q ? '0 : lk_ctr[rb];
    assign rd_taken  = rd_ctr[CW-1];
    assign rd_valid  = rd_valid_q;
    assign init_busy = init_busy_q;
    assign q_count   = q_cnt_q;
    assign wr_drop   = wr_drop_q;

endmodule

// File: tb/tb_ght_sc_table.sv
// Bench for ght_sc_table: directed scenarios plus random traffic against a
// per-index counter model with a FIFO of deferred updates.
module tb_ght_sc_table;

    localparam int IDX_W = 11;
    localparam int BANK_BITS = 3;
    localparam int CW = 2;
    localparam int QD = 4;
    localparam int NB = 8;
    localparam int ROWS = 256;
    localparam int NIDX = 2048;
    localparam int WEAK = 1;
    localparam int MAXC = 3;

    logic             clk = 1'b0;
    logic             rst, rd_en, fstall, wr0_en, wr0_taken, wr1_en, wr1_taken;
    logic [IDX_W-1:0] rd_idx, wr0_idx, wr1_idx;
    logic             rd_valid, rd_taken, init_busy, wr_drop;
    logic [CW-1:0]    rd_ctr;
    logic [2:0]       q_count;

    always #5 clk = ~clk;

    ght_sc_table #(.IDX_W(IDX_W), .BANK_BITS(BANK_BITS), .CW(CW), .QD(QD)) dut (
        .clk(clk), .rst(rst), .rd_en(rd_en), .fstall(fstall), .rd_idx(rd_idx),
        .rd_valid(rd_valid), .rd_taken(rd_taken), .rd_ctr(rd_ctr),
        .wr0_en(wr0_en), .wr0_idx(wr0_idx), .wr0_taken(wr0_taken),
        .wr1_en(wr1_en), .wr1_idx(wr1_idx), .wr1_taken(wr1_taken),
        .init_busy(init_busy), .q_count(q_count), .wr_drop(wr_drop)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: one counter per index, pending updates in a FIFO.
    typedef struct { int idx; bit taken; } upd_t;
    int   m_ctr [NIDX];
    upd_t m_q [$];
    bit   m_busy, m_valid, m_drop;
    int   m_cnt, m_idx;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic void bump(input int idx, input bit t);
        if (t) m_ctr[idx] = (m_ctr[idx] == MAXC) ? MAXC : m_ctr[idx] + 1;
        else   m_ctr[idx] = (m_ctr[idx] == 0) ? 0 : m_ctr[idx] - 1;
    endfunction

    function automatic void enqueue(input int idx, input bit t);
        upd_t u;
        u.idx = idx;
        u.taken = t;
        if (m_q.size() < QD) m_q.push_back(u);
        else m_drop = 1;
    endfunction

    function automatic void mstep();
        bit   was_busy, hv, l0, l1;
        int   hbank, b0, b1;
        upd_t h;
        if (rst) begin
            m_busy = 1; m_cnt = 0; m_q.delete(); m_valid = 0; m_drop = 0; m_idx = 0;
            return;
        end
        was_busy = m_busy;
        m_drop = 0;
        if (m_busy) begin
            for (int b = 0; b < NB; b++) m_ctr[m_cnt * NB + b] = WEAK;
            m_cnt++;
            if (m_cnt == ROWS) m_busy = 0;
        end else begin
            hv = (m_q.size() > 0);
            hbank = -1;
            b0 = int'(wr0_idx) % NB;
            b1 = int'(wr1_idx) % NB;
            if (hv) begin
                h = m_q.pop_front();
                hbank = h.idx % NB;
                bump(h.idx, h.taken);
            end
            l0 = 0; l1 = 0;
            if (wr0_en) begin
                if (hv && b0 == hbank) l0 = 1;
                else bump(int'(wr0_idx), wr0_taken);
            end
            if (wr1_en) begin
                if ((hv && b1 == hbank) || (wr0_en && b1 == b0)) l1 = 1;
                else bump(int'(wr1_idx), wr1_taken);
            end
            if (l0) enqueue(int'(wr0_idx), wr0_taken);
            if (l1) enqueue(int'(wr1_idx), wr1_taken);
        end
        if (rd_en) m_idx = int'(rd_idx);
        if (!fstall) m_valid = rd_en && !was_busy;
    endfunction

    task automatic tick();
        @(posedge clk);
        mstep();
        #1;
        chk("init_busy", 32'(init_busy), 32'(m_busy));
        chk("rd_valid", 32'(rd_valid), 32'(m_valid));
        chk("q_count", 32'(q_count), 32'(m_q.size()));
        chk("wr_drop", 32'(wr_drop), 32'(m_drop));
        if (m_valid) begin
            chk("rd_ctr", 32'(rd_ctr), 32'(m_ctr[m_idx]));
            chk("rd_taken", 32'(rd_taken), 32'(m_ctr[m_idx] >> (CW - 1)));
        end
    endtask

    task automatic idle();
        rd_en = 0; fstall = 0; wr0_en = 0; wr1_en = 0;
    endtask

    task automatic read_at(input int idx, input int exp, input string tag);
        idle();
        rd_en = 1; rd_idx = 11'(idx);
        tick();
        rd_en = 0;
        chk(tag, 32'(rd_ctr), 32'(exp));
    endtask

    task automatic count_init(input string tag);
        int n;
        n = 0;
        while (init_busy && n < 400) begin
            n++;
            tick();
        end
        chk(tag, 32'(n), 32'(ROWS));
    endtask

    int qexp [6] = '{1, 2, 3, 4, 4, 4};
    int dexp [6] = '{0, 0, 0, 0, 1, 1};
    int up_seq [3] = '{2, 3, 3};
    int dn_seq [4] = '{2, 1, 0, 0};

    initial begin
        rst = 1; idle();
        rd_idx = '0; wr0_idx = '0; wr1_idx = '0; wr0_taken = 0; wr1_taken = 0;
        tick();
        tick();
        // Reset state.
        chk("rst_busy", 32'(init_busy), 32'd1);
        chk("rst_qcount", 32'(q_count), 32'd0);
        chk("rst_rd_valid", 32'(rd_valid), 32'd0);
        chk("rst_rd_ctr", 32'(rd_ctr), 32'd0);
        chk("rst_rd_taken", 32'(rd_taken), 32'd0);
        chk("rst_wr_drop", 32'(wr_drop), 32'd0);
        rst = 0;
        count_init("init_len");

        // First lookup after init returns weakly-not-taken.
        read_at(11'h155, WEAK, "init_val");
        chk("init_valid", 32'(rd_valid), 32'd1);
        chk("init_taken", 32'(rd_taken), 32'd0);

        // Saturation up then down on 0x010, reading at the same edge as each write.
        for (int i = 0; i < 7; i++) begin
            idle();
            wr0_en = 1; wr0_idx = 11'h010; wr0_taken = (i < 3);
            rd_en = 1; rd_idx = 11'h010;
            tick();
            chk("sat_seq", 32'(rd_ctr), 32'((i < 3) ? up_seq[i] : dn_seq[i - 3]));
        end

        // Same-bank pair: port 1 replays the following cycle.
        idle();
        wr0_en = 1; wr0_idx = 11'h011; wr0_taken = 1;
        wr1_en = 1; wr1_idx = 11'h019; wr1_taken = 1;
        tick();
        chk("pair_q1", 32'(q_count), 32'd1);
        idle();
        tick();
        chk("pair_q0", 32'(q_count), 32'd0);
        read_at(11'h011, 2, "pair_p0");
        read_at(11'h019, 2, "pair_p1");

        // Sustained bank-2 conflicts fill the queue and drop.
        for (int k = 0; k < 6; k++) begin
            idle();
            wr0_en = 1; wr0_idx = 11'(2 + 16 * k); wr0_taken = 1'($urandom_range(0, 1));
            wr1_en = 1; wr1_idx = 11'(10 + 16 * k); wr1_taken = 1'($urandom_range(0, 1));
            tick();
            chk("fill_q", 32'(q_count), 32'(qexp[k]));
            chk("fill_drop", 32'(wr_drop), 32'(dexp[k]));
        end
        idle();
        repeat (6) tick();
        chk("drain_q", 32'(q_count), 32'd0);
        for (int k = 0; k < 6; k++) read_at(2 + 16 * k, m_ctr[2 + 16 * k], "fill_ctr");

        // Write-first: update and lookup registered at the same edge.
        idle();
        wr0_en = 1; wr0_idx = 11'h020; wr0_taken = 1;
        rd_en = 1; rd_idx = 11'h020;
        tick();
        chk("wr_first", 32'(rd_ctr), 32'd2);

        // Random traffic over a small index pool to provoke conflicts.
        for (int c = 0; c < 500; c++) begin
            rd_en = 1'($urandom_range(0, 1));
            fstall = ($urandom_range(0, 3) == 0);
            rd_idx = 11'($urandom_range(0, 63));
            wr0_en = 1'($urandom_range(0, 1));
            wr0_idx = 11'($urandom_range(0, 31));
            wr0_taken = 1'($urandom_range(0, 1));
            wr1_en = 1'($urandom_range(0, 1));
            wr1_idx = 11'($urandom_range(0, 31));
            wr1_taken = 1'($urandom_range(0, 1));
            tick();
        end
        idle();
        repeat (6) tick();

        // Reset mid-sweep with updates offered during init.
        rst = 1;
        tick();
        rst = 0;
        wr0_en = 1; wr1_en = 1;
        for (int r = 0; r < 100; r++) begin
            wr0_idx = 11'($urandom_range(0, NIDX - 1));
            wr1_idx = wr0_idx;
            tick();
        end
        chk("init_wr_q", 32'(q_count), 32'd0);
        chk("init_wr_drop", 32'(wr_drop), 32'd0);
        idle();
        rst = 1;
        tick();
        rst = 0;
        count_init("reinit_len");
        read_at(11'h010, WEAK, "reinit_val");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
